// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between the
// i-cache and d-cache fill paths; one access in flight at a time.
module cache_mem_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [14:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic        i_gnt,
    output logic        i_done,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [14:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [14:0] m_addr,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata
);
    // state    | meaning
    // S_IDLE   | no access in flight, arbitrating
    // S_ACCESS | grant + memory strobe cycle
    // S_WAIT   | counting down memory latency
    // S_DONE   | completion pulse, arbitrating for the next access
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      r_state;
    logic        r_sel_i;
    logic        r_prio_i;
    logic        r_we;
    logic [14:0] r_addr;
    logic [15:0] r_wdata;
    logic [3:0]  r_cnt;
    logic        r_i_gnt;
    logic        r_d_gnt;
    logic        r_i_done;
    logic        r_d_done;
    logic [15:0] r_i_rdata;
    logic [15:0] r_d_rdata;
    logic        r_m_en;

    logic        w_any_req;
    logic        w_pick_i;

    assign w_any_req = i_req | d_req;
    // i-side wins when alone, or on a tie when the pointer favours it
    assign w_pick_i  = i_req & (~d_req | r_prio_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel_i   <= 1'b0;
            r_prio_i  <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_i_gnt   <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_m_en    <= 1'b0;
        end else begin
            r_i_gnt  <= 1'b0;
            r_d_gnt  <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_m_en   <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_any_req) begin
                        r_sel_i  <= w_pick_i;
                        r_prio_i <= ~w_pick_i;
                        r_we     <= w_pick_i ? i_we    : d_we;
                        r_addr   <= w_pick_i ? i_addr  : d_addr;
                        r_wdata  <= w_pick_i ? i_wdata : d_wdata;
                        r_i_gnt  <= w_pick_i;
                        r_d_gnt  <= ~w_pick_i;
                        r_m_en   <= 1'b1;
                        r_state  <= S_ACCESS;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_cnt   <= LAT;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                        if (r_sel_i) begin
                            r_i_done <= 1'b1;
                            if (!r_we) r_i_rdata <= m_rdata;
                        end else begin
                            r_d_done <= 1'b1;
                            if (!r_we) r_d_rdata <= m_rdata;
                        end
                    end
                    r_cnt <= r_cnt - 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_gnt   = r_i_gnt;
    assign d_gnt   = r_d_gnt;
    assign i_done  = r_i_done;
    assign d_done  = r_d_done;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign m_en    = r_m_en;
    assign m_we    = r_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for write/read-back and reset during a read.
module tb_cache_mem_arbiter;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_we, d_req, d_we;
    logic [14:0] i_addr, d_addr;
    logic [15:0] i_wdata, d_wdata;
    logic        i_gnt, i_done, d_gnt, d_done;
    logic [15:0] i_rdata, d_rdata;
    logic        m_en, m_we;
    logic [14:0] m_addr;
    logic [15:0] m_wdata, m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_gnt(i_gnt), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Memory model: read data is valid only in the cycle MEM_LAT after m_en.
    logic [15:0] mem [0:32767];
    logic        vp0, vp1;
    logic [14:0] ap0, ap1;

    always @(posedge clk) begin
        if (rst) begin
            vp0 <= 1'b0;
            vp1 <= 1'b0;
            mem[2]  <= 16'd1234;
            mem[5]  <= 16'd71;
            mem[8]  <= 16'h0BAD;
            mem[22] <= 16'd77;
        end else begin
            vp0 <= m_en && !m_we;
            ap0 <= m_addr;
            vp1 <= vp0;
            ap1 <= ap0;
            if (m_en && m_we) mem[m_addr] <= m_wdata;
        end
    end

    assign m_rdata = vp1 ? mem[ap1] : 16'hBAD0;

    typedef struct {
        logic        rst;
        logic        ir, iw;
        logic [14:0] ia;
        logic        dr, dw;
        logic [14:0] da;
        logic [15:0] dwd;
        logic [4:0]  ctl;
        logic [15:0] ird, drd;
        logic        mwe;
        logic [14:0] ma;
        logic [15:0] mwd;
    } vec_t;

    vec_t tbl[$];

    // ctl = {i_gnt, i_done, d_gnt, d_done, m_en}
    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] IG = 5'b10001;
    localparam logic [4:0] ID = 5'b01000;
    localparam logic [4:0] DG = 5'b00101;
    localparam logic [4:0] DD = 5'b00010;

    task automatic add(input logic r, input logic ir, input logic iw, input logic [14:0] ia,
                       input logic dr, input logic dw, input logic [14:0] da, input logic [15:0] dwd,
                       input logic [4:0] ctl, input logic [15:0] ird, input logic [15:0] drd,
                       input logic mwe, input logic [14:0] ma, input logic [15:0] mwd);
        vec_t v;
        v.rst = r; v.ir = ir; v.iw = iw; v.ia = ia;
        v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.ctl = ctl; v.ird = ird; v.drd = drd;
        v.mwe = mwe; v.ma = ma; v.mwd = mwd;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic access(input logic side_i, input logic we, input logic [14:0] addr,
                          input logic [15:0] wdata, output int lat_g, output int lat_d,
                          output logic g_we, output logic [14:0] g_addr, output logic [15:0] g_wdata);
        lat_g = -1;
        lat_d = -1;
        g_we = 1'bx; g_addr = 'x; g_wdata = 'x;
        if (side_i) begin
            i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
        end else begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end
        for (int c = 1; c <= 10; c++) begin
            step();
            if ((side_i ? i_gnt : d_gnt) && m_en) begin
                lat_g = c;
                g_we = m_we; g_addr = m_addr; g_wdata = m_wdata;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        if (lat_g > 0) begin
            for (int c = 1; c <= 10; c++) begin
                step();
                if (side_i ? i_done : d_done) begin
                    lat_d = c;
                    break;
                end
            end
        end
    endtask

    int          lg, ld, n_done;
    logic        gwe;
    logic [14:0] ga;
    logic [15:0] gwd;

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        //   rst ir iw ia  dr dw da  dwd  ctl ird   drd  mwe ma mwd
        add(1, 1, 0, 2,  1, 1, 8, 100, NO, 0,    0,   0, 0, 0);
        add(1, 1, 0, 2,  1, 1, 8, 100, NO, 0,    0,   0, 0, 0);
        add(0, 1, 0, 2,  1, 1, 8, 100, DG, 0,    0,   1, 8, 100);
        add(0, 1, 0, 2,  0, 0, 0, 0,   NO, 0,    0,   0, 0, 0);
        add(0, 1, 0, 2,  0, 0, 0, 0,   NO, 0,    0,   0, 0, 0);
        add(0, 1, 0, 2,  0, 0, 0, 0,   DD, 0,    0,   0, 0, 0);
        add(0, 1, 0, 2,  0, 0, 0, 0,   IG, 0,    0,   0, 2, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 0,    0,   0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 0,    0,   0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   ID, 1234, 0,   0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 1234, 0,   0, 0, 0);
        add(0, 1, 0, 5,  0, 0, 0, 0,   IG, 1234, 0,   0, 5, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 1234, 0,   0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 1234, 0,   0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   ID, 71,   0,   0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 71,   0,   0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   DG, 71,   0,   0, 8, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   NO, 71,   0,   0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   NO, 71,   0,   0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   DD, 71,   100, 0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   IG, 71,   100, 0, 5, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   NO, 71,   100, 0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   NO, 71,   100, 0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   ID, 71,   100, 0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   DG, 71,   100, 0, 8, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   NO, 71,   100, 0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   NO, 71,   100, 0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   DD, 71,   100, 0, 0, 0);
        add(0, 1, 0, 5,  1, 0, 8, 0,   IG, 71,   100, 0, 5, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 71,   100, 0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 71,   100, 0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   ID, 71,   100, 0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   NO, 71,   100, 0, 0, 0);

        @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            rst = tbl[k].rst;
            i_req = tbl[k].ir; i_we = tbl[k].iw; i_addr = tbl[k].ia; i_wdata = '0;
            d_req = tbl[k].dr; d_we = tbl[k].dw; d_addr = tbl[k].da; d_wdata = tbl[k].dwd;
            step();
            chk($sformatf("v%0d ctl", k), 32'({i_gnt, i_done, d_gnt, d_done, m_en}), 32'(tbl[k].ctl));
            chk($sformatf("v%0d i_rdata", k), 32'(i_rdata), 32'(tbl[k].ird));
            chk($sformatf("v%0d d_rdata", k), 32'(d_rdata), 32'(tbl[k].drd));
            if (tbl[k].ctl[0] || tbl[k].rst)
                chk($sformatf("v%0d mem_cmd", k), {m_we, m_addr, m_wdata},
                    {tbl[k].mwe, tbl[k].ma, tbl[k].mwd});
        end

        // d-write then back-to-back d-read of a high address
        access(1'b0, 1'b1, 15'b010000000001001, 16'd77, lg, ld, gwe, ga, gwd);
        chk("wr gnt_lat", 32'(lg), 32'd1);
        chk("wr mem_cmd", {gwe, ga, gwd}, {1'b1, 15'b010000000001001, 16'd77});
        chk("wr done_lat", 32'(ld), 32'd3);
        chk("wr d_rdata hold", 32'(d_rdata), 32'd100);
        access(1'b0, 1'b0, 15'b010000000001001, 16'd0, lg, ld, gwe, ga, gwd);
        chk("rd gnt_lat", 32'(lg), 32'd1);
        chk("rd mem_cmd", 32'({gwe, ga}), 32'({1'b0, 15'b010000000001001}));
        chk("rd done_lat", 32'(ld), 32'd3);
        chk("rd d_rdata", 32'(d_rdata), 32'd77);
        chk("rd i_rdata hold", 32'(i_rdata), 32'd71);

        // reset while an i-read sits in WAIT
        step();
        i_req = 1'b1; i_we = 1'b0; i_addr = 15'd5;
        step();
        chk("rw gnt", 32'({i_gnt, m_en}), 32'b11);
        i_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rw ctl", 32'({i_gnt, i_done, d_gnt, d_done, m_en}), 32'd0);
        chk("rw mem_cmd", {m_we, m_addr, m_wdata}, 32'd0);
        chk("rw i_rdata", 32'(i_rdata), 32'd0);
        chk("rw d_rdata", 32'(d_rdata), 32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (i_done || d_done || i_gnt || d_gnt) n_done++;
        end
        chk("rw no_done", 32'(n_done), 32'd0);
        access(1'b1, 1'b0, 15'd22, 16'd0, lg, ld, gwe, ga, gwd);
        chk("rw2 gnt_lat", 32'(lg), 32'd1);
        chk("rw2 addr", 32'(ga), 32'd22);
        chk("rw2 done_lat", 32'(ld), 32'd3);
        chk("rw2 i_rdata", 32'(i_rdata), 32'd77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
